// File: rtl/vram_writer.sv
// Cell-colour VRAM for an 80x60 character-cell display: CPU single-cell writes,
// a rectangle fill engine sharing the write port, and a registered read port for the VGA side.
module vram_writer #(
  parameter int CELLS = 4800,
  parameter int COLS  = 80
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_valid,
  input  logic [12:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  input  logic        fill_start,
  input  logic [6:0]  fill_x0,
  input  logic [6:0]  fill_x1,
  input  logic [5:0]  fill_y0,
  input  logic [5:0]  fill_y1,
  input  logic [11:0] fill_color,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [12:0] vram_addr,
  output logic [11:0] d_out,
  output logic [1:0]  fsm_state
);

  // Handshake: a CPU write is taken on any rising edge where wr_valid && wr_ready;
  // wr_ready is simply !busy, so CPU and fill engine never share a write cycle.

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FINISH = 2'd2} state_t;

  localparam int          ROWS      = CELLS / COLS;
  localparam logic [12:0] LAST_CELL = 13'(CELLS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);

  state_t      state;
  logic [6:0]  cx, x0_q, x1_q;
  logic [5:0]  cy, y1_q;
  logic [11:0] color_q;

  logic [11:0] mem [0:CELLS-1];

  logic        fill_ok;
  logic [12:0] fill_addr;
  logic        we;
  logic [12:0] waddr;
  logic [11:0] wdata;

  assign wr_ready  = !busy;
  assign fsm_state = state;

  assign fill_ok = (fill_x0 <= fill_x1) && (fill_x1 <= LAST_COL) &&
                   (fill_y0 <= fill_y1) && (fill_y1 <= LAST_ROW);

  // cy*80 + cx built from shifts so no multiplier is needed.
  assign fill_addr = {1'b0, cy, 6'b0} + {3'b0, cy, 4'b0} + {6'b0, cx};

  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = wr_data;
    if (state == FILL) begin
      we    = 1'b1;
      waddr = fill_addr;
      wdata = color_q;
    end else if (wr_valid && wr_ready && (wr_addr <= LAST_CELL)) begin
      we = 1'b1;
    end
  end

  // RAM contents survive reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_out <= 12'h000;
    end else if (vram_addr <= LAST_CELL) begin
      d_out <= mem[vram_addr];
    end else begin
      d_out <= 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            if (fill_ok) begin
              x0_q    <= fill_x0;
              x1_q    <= fill_x1;
              y1_q    <= fill_y1;
              color_q <= fill_color;
              cx      <= fill_x0;
              cy      <= fill_y0;
              busy    <= 1'b1;
              state   <= FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cx == x1_q) begin
            cx <= x0_q;
            if (cy == y1_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              cy <= cy + 6'd1;
            end
          end else begin
            cx <= cx + 7'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: shadow memory plus an expected-read queue,
// pulse/busy counters sampled on the falling edge.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [6:0]  fill_x0, fill_x1;
  logic [5:0]  fill_y0, fill_y1;
  logic [11:0] fill_color;
  logic        busy, done, err;
  logic [12:0] vram_addr;
  logic [11:0] d_out;
  logic [1:0]  fsm_state;

  vram_writer dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
    .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
    .busy(busy), .done(done), .err(err),
    .vram_addr(vram_addr), .d_out(d_out), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];
  logic [11:0] model [0:4799];

  int busy_cnt, done_cnt, err_cnt, acc_cnt, rdy_bad;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (wr_valid && wr_ready) acc_cnt++;
    if (busy === wr_ready) rdy_bad++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0; rdy_bad = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [12:0] a, input logic [11:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
    if (a < 13'd4800) model[a] = d;
  endtask

  task automatic read_cell(input string tag, input logic [12:0] a);
    vram_addr = a;
    exp_q.push_back((a < 13'd4800) ? model[a] : 12'h000);
    step();
    check(tag, {20'b0, d_out}, {20'b0, exp_q.pop_front()});
  endtask

  task automatic start_fill(input logic [6:0] x0, input logic [6:0] x1,
                            input logic [5:0] y0, input logic [5:0] y1, input logic [11:0] c);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic model_fill(input int x0, input int x1, input int y0, input int y1, input logic [11:0] c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        model[y * 80 + x] = c;
  endtask

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0;
    fill_color = '0; vram_addr = '0;
    clear_counts();
    step(); step(); step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_dout", {20'b0, d_out}, 32'd0);
    check("rst_ready", {31'b0, wr_ready}, 32'd1);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    rstn = 1'b1;

    // basic write / read, out-of-range read and write
    cpu_write(13'd81, 12'hF0A);
    read_cell("rd81", 13'd81);
    read_cell("rd4800", 13'd4800);
    cpu_write(13'd4800, 12'hBAD);
    read_cell("rd4800_after_wr", 13'd4800);

    // small rectangle fill with guarded neighbours
    cpu_write(13'd85, 12'h555);
    cpu_write(13'd161, 12'h161);
    cpu_write(13'd82, 12'h000);
    clear_counts();
    start_fill(7'd2, 7'd4, 6'd1, 6'd2, 12'h0F0);
    check("fill_busy_rise", {31'b0, busy}, 32'd1);
    check("fill_state", {30'b0, fsm_state}, 32'd1);
    wait_done("fill6_done", 20);
    check("finish_busy", {31'b0, busy}, 32'd0);
    step();
    check("fill6_busy_cycles", busy_cnt, 32'd6);
    check("fill6_done_cnt", done_cnt, 32'd1);
    check("fill6_ready_bad", rdy_bad, 32'd0);
    check("back_idle", {30'b0, fsm_state}, 32'd0);
    model_fill(2, 4, 1, 2, 12'h0F0);
    read_cell("rd82", 13'd82);
    read_cell("rd83", 13'd83);
    read_cell("rd84", 13'd84);
    read_cell("rd162", 13'd162);
    read_cell("rd163", 13'd163);
    read_cell("rd164", 13'd164);
    read_cell("rd81_kept", 13'd81);
    read_cell("rd85_kept", 13'd85);
    read_cell("rd161_kept", 13'd161);

    // rejected fills
    cpu_write(13'd5, 12'h0A5);
    clear_counts();
    start_fill(7'd5, 7'd3, 6'd0, 6'd0, 12'hFFF);
    check("err_x_pulse", {31'b0, err}, 32'd1);
    check("err_x_busy", {31'b0, busy}, 32'd0);
    step();
    check("err_x_drop", {31'b0, err}, 32'd0);
    start_fill(7'd5, 7'd80, 6'd0, 6'd0, 12'hFFF);
    check("err_x80_pulse", {31'b0, err}, 32'd1);
    step(); step();
    start_fill(7'd0, 7'd0, 6'd3, 6'd60, 12'hFFF);
    check("err_y60_pulse", {31'b0, err}, 32'd1);
    step();
    check("err_cnt", err_cnt, 32'd3);
    check("err_busy_cnt", busy_cnt, 32'd0);
    read_cell("rd5_kept", 13'd5);

    // read-during-write returns old data
    cpu_write(13'd100, 12'h111);
    vram_addr = 13'd100;
    wr_valid = 1'b1; wr_addr = 13'd100; wr_data = 12'h222;
    exp_q.push_back(model[100]);
    step();
    wr_valid = 1'b0;
    model[100] = 12'h222;
    check("rdw_old", {20'b0, d_out}, {20'b0, exp_q.pop_front()});
    read_cell("rdw_new", 13'd100);

    // simultaneous CPU write and fill start: write lands first, fill overwrites
    wr_valid = 1'b1; wr_addr = 13'd810; wr_data = 12'hABC;
    start_fill(7'd10, 7'd11, 6'd10, 6'd10, 12'h456);
    wr_valid = 1'b1; wr_addr = 13'd900; wr_data = 12'h777;
    step();
    wr_valid = 1'b0;
    wait_done("both_done", 20);
    step();
    model_fill(10, 11, 10, 10, 12'h456);
    read_cell("both_810", 13'd810);
    read_cell("both_811", 13'd811);
    cpu_write(13'd900, 12'h777);
    cpu_write(13'd901, 12'h999);
    wr_valid = 1'b1; wr_addr = 13'd901; wr_data = 12'h888;
    start_fill(7'd20, 7'd20, 6'd0, 6'd0, 12'h321);
    wr_valid = 1'b0;
    wait_done("both2_done", 20);
    step();
    model[901] = 12'h888;
    model[20] = 12'h321;
    read_cell("both2_cpu", 13'd901);
    read_cell("both2_fill", 13'd20);

    // full-screen fill with CPU pressure
    clear_counts();
    start_fill(7'd0, 7'd79, 6'd0, 6'd59, 12'h123);
    wr_valid = 1'b1; wr_addr = 13'd50; wr_data = 12'hEEE;
    check("full_ready_low", {31'b0, wr_ready}, 32'd0);
    wait_done("full_done", 6000);
    wr_valid = 1'b0;
    step();
    check("full_busy_cycles", busy_cnt, 32'd4800);
    check("full_done_cnt", done_cnt, 32'd1);
    check("full_cpu_acc", acc_cnt, 32'd0);
    check("full_ready_bad", rdy_bad, 32'd0);
    model_fill(0, 79, 0, 59, 12'h123);
    read_cell("full_0", 13'd0);
    read_cell("full_4799", 13'd4799);
    read_cell("full_2400", 13'd2400);
    read_cell("full_50", 13'd50);

    // reset during a fill aborts it after cells 0..8
    for (int i = 0; i < 10; i++) cpu_write(13'(i), 12'h000);
    vram_addr = 13'd0;
    clear_counts();
    start_fill(7'd0, 7'd79, 6'd0, 6'd59, 12'h123);
    for (int i = 0; i < 9; i++) step();
    rstn = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_dout", {20'b0, d_out}, 32'd0);
    check("abort_ready", {31'b0, wr_ready}, 32'd1);
    check("abort_state", {30'b0, fsm_state}, 32'd0);
    step(); step();
    check("abort_done_cnt", done_cnt, 32'd0);
    check("abort_err_cnt", err_cnt, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) model[i] = 12'h123;
    cpu_write(13'd200, 12'h5A5);
    for (int i = 0; i < 10; i++) read_cell($sformatf("abort_rd%0d", i), 13'(i));
    read_cell("post_rst_wr", 13'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 The block SHALL have parameter CELLS, default 4800, the number of 8x8-pixel cells (80 columns x 60 rows).
REQ-002 The block SHALL have parameter COLS, default 80, the cells per row.
REQ-003 clk  input  1  single clock (25 MHz pixel clock); all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  CPU single-cell write request.
REQ-006 wr_addr  input  13  linear cell address of the write.
REQ-007 wr_data  input  12  colour {r[3:0],g[3:0],b[3:0]} for the write.
REQ-008 wr_ready  output  1  write accepted when wr_valid && wr_ready on a rising edge.
REQ-009 fill_start  input  1  one-cycle pulse that starts a rectangle fill.
REQ-010 fill_x0, fill_x1  input  7 each  inclusive column bounds.
REQ-011 fill_y0, fill_y1  input  6 each  inclusive row bounds.
REQ-012 fill_color  input  12  fill colour.
REQ-013 busy  output  1  fill engine active.
REQ-014 done  output  1  one-cycle pulse when a fill completes.
REQ-015 err  output  1  one-cycle pulse when a fill command is rejected.
REQ-016 vram_addr  input  13  display read address from the VGA controller.
REQ-017 d_out  output  12  cell colour for vram_addr; this drives the controller's d_in.

Function
REQ-018 The block SHALL hold a CELLS x 12-bit RAM with one write port and one independent read port.
REQ-019 Read port: d_out SHALL equal RAM[vram_addr] registered, so it is valid exactly 1 cycle after vram_addr is presented.
REQ-020 Read port: d_out SHALL be 12'h000 when vram_addr >= CELLS.
REQ-021 Read port: a read and a write to the same address in the same cycle SHALL return the old data.
REQ-022 wr_ready SHALL equal !busy, combinationally.
REQ-023 An accepted write with wr_addr < CELLS SHALL update RAM[wr_addr] at that edge.
REQ-024 An accepted write with wr_addr >= CELLS SHALL be acknowledged and discarded.
REQ-025 FSM states SHALL be IDLE, FILL and FINISH.
REQ-026 IDLE: fill_start with x0<=x1<=COLS-1 and y0<=y1<=59 SHALL latch all fill inputs, set cx=x0 and cy=y0, and go to FILL; busy SHALL rise the next cycle.
REQ-027 IDLE: fill_start with an invalid rectangle SHALL pulse err for one cycle, leave the state at IDLE and write nothing.
REQ-028 FILL: each cycle SHALL write the latched colour to address cy*80+cx, computed as {cy,6'b0}+{cy,4'b0}+cx in 13 bits.
REQ-029 FILL: cx SHALL increment each cycle; when cx==x1, cx SHALL wrap to x0 and cy SHALL increment.
REQ-030 FILL: after writing the cell (x1,y1) the FSM SHALL go to FINISH.
REQ-031 FILL: fill_start SHALL be ignored while in FILL.
REQ-032 A fill SHALL take exactly (x1-x0+1)*(y1-y0+1) write cycles.
REQ-033 FINISH: done SHALL be 1 for one cycle, busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-034 Since wr_ready is low while busy, the CPU and fill engine SHALL never write in the same cycle.
REQ-035 In IDLE, a fill_start and a wr_valid in the same cycle SHALL both be accepted; the CPU write completes first and the fill may overwrite it.
REQ-036 Fill ordering SHALL be row-major and never address a cell outside the latched rectangle.

Reset
REQ-037 While rstn=0: busy=0, done=0, err=0, d_out=12'h000, FSM=IDLE, cx/cy/latched fields=0; wr_ready SHALL follow busy and read 1.
REQ-038 RAM contents SHALL NOT be cleared by reset.
REQ-039 Reset during FILL SHALL abort immediately; cells already written keep their values, with no done or err pulse.
REQ-040 After rstn deasserts, the block SHALL accept commands on the first rising edge.

Verification
REQ-041 Write addr 13'd81 data 12'hF0A, then set vram_addr=81 -> d_out=12'hF0A one cycle later; vram_addr=4800 -> d_out=12'h000.
REQ-042 Fill x0=2,x1=4,y0=1,y1=2, colour 12'h0F0 -> exactly 6 busy cycles writing addresses 82,83,84,162,163,164 in order; done pulses once; wr_ready=0 throughout; neighbouring addresses 81, 85 and 161 are unchanged.
REQ-043 Fill x0=5,x1=3 -> err pulses for one cycle; busy stays 0; no RAM change. Repeat with x1=80 -> same result.
REQ-044 Full-screen fill 0..79 x 0..59, colour 12'h123 -> 4800 busy cycles; reads at addresses 0, 4799 and 2400 return 12'h123; wr_valid during the fill is not accepted.
REQ-045 Assert rstn=0 at the 10th cycle of the REQ-044 fill -> busy=0 and d_out=0 asynchronously; addresses 0..8 read 12'h123 afterwards; no done pulse.
REQ-046 vram_addr==wr_addr==100 in the same cycle, old 12'h111, new 12'h222 -> d_out=12'h111 the next cycle and 12'h222 the cycle after.
